dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half/word loads and stores, registered load data,
// sticky error flag with a saturating error count. Define DMEM_RESPONDER_MMIO_EN to add the MMIO window.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic [2:0]  memop,
  input  logic        we,
  input  logic        re,
  output logic [31:0] dataout,
  output logic        err
);

  localparam int unsigned WORDS = 2 ** (ADDR_WIDTH - 2);

  // Handshake: there is no backpressure. we/re are single-cycle requests sampled on every
  // rising edge; a load's result appears on dataout one edge later and holds until the next load.

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] off, input logic [2:0] op);
    logic [31:0] r;
    r = w;
    case (op[1:0])
      2'b00:   r[{off, 3'b000} +: 8] = d[7:0];
      2'b01:   if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  logic [31:0] mem [WORDS];
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0] ram_word;
  logic [31:0] src_word;
  logic        ram_we;
  logic [31:0] ram_wdata;

  logic [31:0] dataout_q, dataout_d;
  logic        err_q, err_d;
  logic [7:0]  errcnt_q, errcnt_d;

  logic half_op, word_op, misaligned, invalid, bad;

  assign word_idx  = addr[ADDR_WIDTH-1:2];
  assign ram_word  = mem[word_idx];
  assign ram_wdata = store_merge(ram_word, datain, addr[1:0], memop);

  always_comb begin
    half_op    = (memop[1:0] == 2'b01);
    word_op    = (memop == 3'b010);
    misaligned = (half_op && addr[0]) || (word_op && (addr[1:0] != 2'b00));
    // Unsigned variants only make sense for loads.
    invalid    = (memop == 3'b011) || (memop[2:1] == 2'b11) || (memop[2] && we);
    bad        = (re || we) && (misaligned || invalid);
  end

`ifdef DMEM_RESPONDER_MMIO_EN
  logic        in_mmio;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] mmio_word;

  assign in_mmio = (addr[31:4] == MMIO_BASE[31:4]);

  always_comb begin
    case (addr[3:2])
      2'd0:    mmio_word = cycle_q[31:0];
      2'd1:    mmio_word = cycle_q[63:32];
      2'd2:    mmio_word = {16'h0, errcnt_q, 7'h0, err_q};
      default: mmio_word = scratch_q;
    endcase
    src_word = in_mmio ? mmio_word : ram_word;
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH];
  assign src_word = ram_word;
`endif

  always_comb begin
    dataout_d = dataout_q;
    err_d     = err_q;
    errcnt_d  = errcnt_q;
    ram_we    = 1'b0;
`ifdef DMEM_RESPONDER_MMIO_EN
    cycle_d   = cycle_q + 64'd1;
    scratch_d = scratch_q;
    // The clear is applied first so a simultaneous new error leaves err=1, errcnt=1.
    if (we && in_mmio && (addr[3:2] == 2'd2)) begin
      err_d    = 1'b0;
      errcnt_d = 8'h00;
    end
`endif
    if (bad) begin
      dataout_d = 32'h0;
      err_d     = 1'b1;
      errcnt_d  = (errcnt_d == 8'hFF) ? 8'hFF : errcnt_d + 8'd1;
    end else begin
      if (re) dataout_d = load_extract(src_word, addr[1:0], memop);
`ifdef DMEM_RESPONDER_MMIO_EN
      if (we && in_mmio) begin
        if (addr[3:2] == 2'd3) scratch_d = store_merge(scratch_q, datain, addr[1:0], memop);
      end else if (we) begin
        ram_we = !reset;
      end
`else
      if (we) ram_we = !reset;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataout_q <= 32'h0;
      err_q     <= 1'b0;
      errcnt_q  <= 8'h00;
`ifdef DMEM_RESPONDER_MMIO_EN
      cycle_q   <= 64'h0;
      scratch_q <= 32'h0;
`endif
    end else begin
      dataout_q <= dataout_d;
      err_q     <= err_d;
      errcnt_q  <= errcnt_d;
`ifdef DMEM_RESPONDER_MMIO_EN
      cycle_q   <= cycle_d;
      scratch_q <= scratch_d;
`endif
    end
  end

  // RAM has no reset; the read above is taken before this write, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (ram_we) mem[word_idx] <= ram_wdata;
  end

  assign dataout = dataout_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// against a byte-addressed reference model. MMIO checks compile with DMEM_RESPONDER_MMIO_EN.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] datain;
  logic [2:0]  memop;
  logic        we;
  logic        re;
  logic [31:0] dataout;
  logic        err;

  int checks = 0;
  int errors = 0;

  localparam int unsigned AMASK = (1 << 15) - 1;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic [7:0]  mm [int];
  logic [31:0] exp_dout;
  logic        exp_err;
  logic [7:0]  exp_cnt;

  dmem_responder dut (
    .clk(clk), .reset(reset), .addr(addr), .datain(datain), .memop(memop),
    .we(we), .re(re), .dataout(dataout), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory is a flat little-endian byte array; each access is judged by size rules.
  task automatic model_op(input bit w, input bit r, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d, input bit rst);
    int unsigned size;
    bit inv, mis;
    int unsigned base;
    logic [31:0] val;
    if (rst) begin
      exp_dout = 0; exp_err = 0; exp_cnt = 0;
      return;
    end
    if (!w && !r) return;
    case (op)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 1;
    endcase
    inv = (op == 3'b011) || (op == 3'b110) || (op == 3'b111) ||
          (w && (op == 3'b100 || op == 3'b101));
    mis = !inv && ((a % size) != 0);
    if (inv || mis) begin
      exp_dout = 0;
      exp_err  = 1;
      exp_cnt  = (exp_cnt == 255) ? 8'd255 : exp_cnt + 8'd1;
      return;
    end
    base = a & AMASK;
    if (r) begin
      val = 0;
      for (int i = 0; i < int'(size); i++)
        val = val | ((mm.exists(base + i) ? 32'(mm[base + i]) : 32'h0) << (8 * i));
      if (op[2] == 1'b0 && size < 4 && val[8 * size - 1])
        val = val | (32'hFFFF_FFFF << (8 * size));
      exp_dout = val;
    end
    if (w) begin
      for (int i = 0; i < int'(size); i++) mm[base + i] = d[8 * i +: 8];
    end
  endtask

  task automatic step(input bit w, input bit r, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] d, input bit rst);
    reset = rst; we = w; re = r; memop = op; addr = a; datain = d;
    @(posedge clk);
    #1;
    model_op(w, r, op, a, d, rst);
    reset = 0; we = 0; re = 0;
  endtask

  task automatic test_reset;
    step(0, 0, 3'b000, 0, 0, 1);
    step(1, 1, 3'b010, 32'h40, 32'h5555_5555, 1);
    checks++; if (dataout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dataout); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (dut.errcnt_q !== 8'h0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", dut.errcnt_q); end
  endtask

  task automatic test_load_extend;
    step(1, 0, 3'b010, 32'h10, 32'h8765_4321, 0);
    step(0, 1, 3'b000, 32'h13, 0, 0);
    checks++; if (dataout !== 32'hFFFF_FF87) begin errors++; $display("FAIL lb_13 got %h exp ffffff87", dataout); end
    step(0, 1, 3'b100, 32'h12, 0, 0);
    checks++; if (dataout !== 32'h0000_0065) begin errors++; $display("FAIL lbu_12 got %h exp 00000065", dataout); end
    step(0, 1, 3'b001, 32'h12, 0, 0);
    checks++; if (dataout !== 32'hFFFF_8765) begin errors++; $display("FAIL lh_12 got %h exp ffff8765", dataout); end
    step(0, 1, 3'b101, 32'h12, 0, 0);
    checks++; if (dataout !== exp_dout) begin errors++; $display("FAIL lhu_12 got %h exp %h", dataout, exp_dout); end
  endtask

  task automatic test_store_lanes;
    step(1, 0, 3'b010, 32'h20, 32'h0, 0);
    step(1, 0, 3'b000, 32'h21, 32'h1234_56AB, 0);
    step(1, 0, 3'b001, 32'h22, 32'h9876_CDEF, 0);
    step(0, 1, 3'b010, 32'h20, 0, 0);
    checks++; if (dataout !== 32'hCDEF_AB00) begin errors++; $display("FAIL lanes_lw got %h exp cdefab00", dataout); end
  endtask

  task automatic test_read_first;
    step(1, 0, 3'b010, 32'h30, 32'h7777_0000, 0);
    step(1, 1, 3'b010, 32'h30, 32'h1, 0);
    checks++; if (dataout !== 32'h7777_0000) begin errors++; $display("FAIL rf_old got %h exp 77770000", dataout); end
    step(0, 1, 3'b010, 32'h30, 0, 0);
    checks++; if (dataout !== 32'h1) begin errors++; $display("FAIL rf_new got %h exp 00000001", dataout); end
  endtask

  task automatic test_idle_and_alias;
    logic [31:0] held;
    held = dataout;
    step(0, 0, 3'b010, 32'h30, 32'hFFFF_FFFF, 0);
    step(0, 0, 3'b011, 32'h31, 32'hFFFF_FFFF, 0);
    checks++; if (dataout !== held || err !== 1'b0) begin errors++; $display("FAIL idle_hold got %h/%b exp %h/0", dataout, err, held); end
    step(1, 0, 3'b010, 32'h0001_8030, 32'hA1B2_C3D4, 0);
    step(0, 1, 3'b010, 32'h30, 0, 0);
    checks++; if (dataout !== 32'hA1B2_C3D4) begin errors++; $display("FAIL alias got %h exp a1b2c3d4", dataout); end
  endtask

  task automatic test_misaligned;
    step(1, 0, 3'b010, 32'h4, 32'hA5A5_A5A5, 0);
    step(0, 1, 3'b010, 32'h5, 0, 0);
    checks++; if (dataout !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL mis_lw got %h/%b exp 0/1", dataout, err); end
    step(1, 0, 3'b001, 32'h7, 32'h0, 0);
    step(1, 0, 3'b010, 32'h6, 32'h0, 0);
    step(0, 1, 3'b010, 32'h4, 0, 0);
    checks++; if (dataout !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mis_nowrite got %h exp a5a5a5a5", dataout); end
    checks++; if (dut.errcnt_q !== 8'd3) begin errors++; $display("FAIL mis_cnt got %0d exp 3", dut.errcnt_q); end
    for (int i = 0; i < 300; i++) step(0, 1, 3'b010, 32'h5, 0, 0);
    checks++; if (dut.errcnt_q !== 8'd255) begin errors++; $display("FAIL cnt_sat got %0d exp 255", dut.errcnt_q); end
  endtask

  task automatic test_invalid;
    step(0, 0, 3'b000, 0, 0, 1);
    step(0, 1, 3'b011, 32'h10, 0, 0);
    checks++; if (dataout !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL inv_op got %h/%b exp 0/1", dataout, err); end
    step(1, 0, 3'b100, 32'h10, 32'hFF, 0);
    step(1, 0, 3'b111, 32'h10, 32'hFF, 0);
    step(0, 1, 3'b010, 32'h10, 0, 0);
    checks++; if (dataout !== 32'h8765_4321) begin errors++; $display("FAIL inv_nowrite got %h exp 87654321", dataout); end
    checks++; if (dut.errcnt_q !== 8'd3) begin errors++; $display("FAIL inv_cnt got %0d exp 3", dut.errcnt_q); end
  endtask

  task automatic test_random;
    logic [2:0] ops [8];
    logic [31:0] a;
    logic [2:0] op;
    bit w, r;
    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    step(0, 0, 3'b000, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 3'b010, 32'h100 + 4 * i, $urandom, 0);
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 4)] : ops[$urandom_range(0, 7)];
      a  = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'h7FFF_8000);
      w  = $urandom_range(0, 1);
      r  = $urandom_range(0, 1);
      step(w, r, op, a, $urandom, 0);
      checks++;
      if (dataout !== exp_dout || err !== exp_err || dut.errcnt_q !== exp_cnt) begin
        errors++;
        $display("FAIL rand_%0d got %h/%b/%0d exp %h/%b/%0d", i, dataout, err, dut.errcnt_q,
                 exp_dout, exp_err, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_access;
    step(1, 0, 3'b010, 32'h40, 32'h1111_1111, 0);
    step(0, 1, 3'b011, 32'h40, 0, 0);
    step(1, 0, 3'b010, 32'h40, 32'hDEAD_BEEF, 1);
    checks++; if (dataout !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL rst_mid got %h/%b exp 0/0", dataout, err); end
    step(0, 1, 3'b010, 32'h40, 0, 0);
    checks++; if (dataout !== 32'h1111_1111) begin errors++; $display("FAIL rst_nowrite got %h exp 11111111", dataout); end
  endtask

`ifdef DMEM_RESPONDER_MMIO_EN
  task automatic test_mmio;
    step(0, 0, 3'b000, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 3'b000, 0, 0, 0);
    step(0, 1, 3'b010, MB, 0, 0);
    checks++; if (dataout !== 32'd10) begin errors++; $display("FAIL cyc_lo got %0d exp 10", dataout); end
    dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    step(0, 0, 3'b000, 0, 0, 0);
    step(0, 1, 3'b010, MB, 0, 0);
    checks++; if (dataout !== 32'h0) begin errors++; $display("FAIL cyc_wrap_lo got %h exp 0", dataout); end
    step(0, 1, 3'b010, MB + 4, 0, 0);
    checks++; if (dataout !== 32'h1) begin errors++; $display("FAIL cyc_hi got %h exp 1", dataout); end
    step(0, 1, 3'b010, 32'h5, 0, 0);
    step(0, 1, 3'b010, MB + 8, 0, 0);
    checks++; if (dataout !== 32'h101) begin errors++; $display("FAIL errstat got %h exp 101", dataout); end
    step(1, 0, 3'b000, MB + 8, 0, 0);
    step(1, 0, 3'b010, MB, 32'h1234, 0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ro_store got err %b exp 0", err); end
    step(0, 1, 3'b010, 32'h5, 0, 0);
    step(1, 0, 3'b010, MB + 9, 0, 0);
    step(0, 1, 3'b010, MB + 8, 0, 0);
    checks++; if (dataout !== 32'h101) begin errors++; $display("FAIL clr_coinc got %h exp 101", dataout); end
    step(1, 0, 3'b010, MB + 12, 32'h1234_5678, 0);
    step(0, 1, 3'b000, MB + 15, 0, 0);
    checks++; if (dataout !== 32'h12) begin errors++; $display("FAIL scratch_lb got %h exp 12", dataout); end
    step(0, 0, 3'b000, 0, 0, 1);
  endtask
`endif

  initial begin
    reset = 1; addr = 0; datain = 0; memop = 0; we = 0; re = 0;
    exp_dout = 0; exp_err = 0; exp_cnt = 0;
    @(negedge clk);
    test_reset();
    test_load_extend();
    test_store_lanes();
    test_read_first();
    test_idle_and_alias();
    test_misaligned();
    test_invalid();
    test_random();
    test_reset_mid_access();
`ifdef DMEM_RESPONDER_MMIO_EN
    test_mmio();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
